// File: rtl/im_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// im_fetch_ctrl
//
// Instruction-fetch controller for the CPU front end. It holds the fetch PC
// and drives the synchronous instruction memory, which has a one-cycle read
// latency. Returned words go into a 2-entry FIFO that feeds decode. A redirect
// from branch/jump resolution flushes both the buffered words and the fetch
// that is still in flight.
//
// Ports
//   clk            : single clock; all state changes on the rising edge
//   rst_n          : asynchronous reset, active low
//   im_addr        : address to the memory (always the registered fetch PC)
//   im_data        : memory read data, valid the cycle after im_addr is sampled
//   halt           : suppresses new fetches; in-flight data is still accepted
//   redirect_valid : 1-cycle pulse; the next fetch comes from redirect_pc
//   redirect_pc    : redirect target; bits [1:0] are ignored
//   inst_valid     : FIFO head is valid
//   inst_ready     : decode accepts the head
//   inst           : instruction word at the FIFO head (0 when empty)
//   inst_pc        : address of inst (0 when empty)
//
// Decode handshake: a word is transferred on every rising edge where
// inst_valid and inst_ready are both 1. inst_valid never depends on
// inst_ready. inst/inst_pc hold steady while inst_valid is 1 and no transfer
// occurs. inst_valid is forced low in a redirect cycle, so no word transfers
// in that cycle.
// -----------------------------------------------------------------------------
module im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]       pc_q,          pc_d;
    logic [1:0][31:0]  fifo_pc_q,     fifo_pc_d;
    logic [1:0][31:0]  fifo_word_q,   fifo_word_d;
    logic              rd_ptr_q,      rd_ptr_d;
    logic              wr_ptr_q,      wr_ptr_d;
    logic [1:0]        count_q,       count_d;
    logic              inflight_q,    inflight_d;
    logic [31:0]       inflight_pc_q, inflight_pc_d;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic        head_valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    // The two low bits of the redirect target are discarded by design.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign head_valid = (count_q != 2'd0);

    // Redirect masks the head so that nothing is consumed in a flush cycle.
    assign inst_valid = head_valid & ~redirect_valid;
    assign pop        = inst_valid & inst_ready;

    // The word returning this cycle is discarded if a redirect is present.
    assign push       = inflight_q & ~redirect_valid;

    // Words already committed (buffered plus in flight) after this cycle's pop.
    // pop implies count_q >= 1, so the subtraction never underflows.
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // A new fetch is only launched if its word is guaranteed a FIFO slot when
    // it returns next cycle; this is what keeps push from ever overflowing.
    assign issue      = ~halt & ~redirect_valid & (occupancy < 3'd2);

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // im_addr comes straight from a register: no input reaches it
    // combinationally.
    assign im_addr = pc_q;
    assign inst    = head_valid ? fifo_word_q[rd_ptr_q] : 32'h0000_0000;
    assign inst_pc = head_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_word_d   = fifo_word_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;

        if (redirect_valid) begin
            // Flush everything, including the word currently returning.
            pc_d       = redirect_target;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            // PC arithmetic wraps modulo 2^32.
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_pc_d = pc_q;
            end
            // A returning word always lands this cycle, so the in-flight flag
            // only survives if a new fetch replaces it.
            inflight_d = issue;

            if (push) begin
                fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                fifo_word_d[wr_ptr_q] = im_data;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fifo_pc_q     <= '0;
            fifo_word_q   <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_word_q   <= fifo_word_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule
